bus_gearbox_6to4: RTL

Stream width converter that unpacks 6-bit packed bus words into a stream of 4-bit nibbles. It is the receive side of the 6-bit packed field bus: it accepts a continuous 6-bit stream and re-emits it as 4-bit fields without losing or reordering bits. Both sides use valid/ready handshakes. A residue buffer holds bits across word boundaries, so 2 input words yield 3 output nibbles.

---
 rtl/bus_gearbox_6to4.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bus_gearbox_6to4.sv
// rtl/bus_gearbox_6to4.sv - 6-bit to 4-bit stream gearbox with residue buffer
//
// Unpacks 6-bit packed words (bit 0 first) into 4-bit nibbles (bit 0 oldest).
// Optional macro: BUS_GEARBOX_FLUSH_EN adds a flush input that pads and emits
// a partial (1..3 bit) residue as a final nibble.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    packed 6-bit input word
//   in_valid   in_data valid
//   in_ready   block accepts in_data this cycle
//   out_data   output nibble
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data this cycle
//   flush      (BUS_GEARBOX_FLUSH_EN only) drain a partial residue
//   nib_count  count of transferred nibbles, wraps modulo 2^CNT_W
module bus_gearbox_6to4 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef BUS_GEARBOX_FLUSH_EN
    input  logic             flush,
`endif
    output logic [CNT_W-1:0] nib_count
);

    logic [9:0]       r_buf;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_nib_count;

    logic             w_push;
    logic             w_pop;
    logic             w_drain_pop;
    logic [9:0]       w_shifted;
    logic [3:0]       w_base;
    logic [9:0]       w_ins;
    logic [9:0]       w_mask;
    logic [9:0]       w_buf_next;
    logic [3:0]       w_cnt_next;

`ifdef BUS_GEARBOX_FLUSH_EN
    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_drain_pop  = 1'b0;
        in_ready     = (r_cnt <= 4'd4);
        out_valid    = (r_cnt >= 4'd4);
        out_data     = r_buf[3:0];
        case (r_state)
            ST_RUN: begin
                // Flush wins over a simultaneous push so the drained nibble
                // holds exactly the residue present when flush was seen.
                if (flush && (r_cnt != 4'd0) && (r_cnt < 4'd4)) begin
                    w_state_next = ST_DRAIN;
                    in_ready     = 1'b0;
                end
            end
            ST_DRAIN: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                // Bits above cnt are stale; zero them for the padded nibble.
                out_data  = r_buf[3:0] & ~(4'hF << r_cnt);
                if (out_ready) begin
                    w_state_next = ST_RUN;
                    w_drain_pop  = 1'b1;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end
`else
    always_comb begin
        w_drain_pop = 1'b0;
        in_ready    = (r_cnt <= 4'd4);
        out_valid   = (r_cnt >= 4'd4);
        out_data    = r_buf[3:0];
    end
`endif

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // Pop shifts the oldest nibble out first; a concurrent push then lands
    // just above the remaining bits.
    assign w_shifted = w_pop ? {4'b0000, r_buf[9:4]} : r_buf;
    assign w_base    = w_pop ? (r_cnt - 4'd4) : r_cnt;
    assign w_ins     = {4'b0000, in_data} << w_base;
    assign w_mask    = 10'h03F << w_base;

    always_comb begin
        w_buf_next = w_shifted;
        w_cnt_next = r_cnt;
        if (w_push) begin
            w_buf_next = (w_shifted & ~w_mask) | w_ins;
        end
        case ({w_push, w_pop})
            2'b10:   w_cnt_next = r_cnt + 4'd6;
            2'b01:   w_cnt_next = r_cnt - 4'd4;
            2'b11:   w_cnt_next = r_cnt + 4'd2;
            default: w_cnt_next = r_cnt;
        endcase
        if (w_drain_pop) begin
            w_buf_next = 10'd0;
            w_cnt_next = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf       <= 10'd0;
            r_cnt       <= 4'd0;
            r_nib_count <= '0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
            if (w_pop) begin
                r_nib_count <= r_nib_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign nib_count = r_nib_count;

endmodule
